// File: rtl/comperator_sort_ctrl.sv
// -----------------------------------------------------------------------------
// comperator_main
//   Unsigned 8-bit magnitude comparator shared by the sort sequencer.
//   Ports:
//     a, b : operands
//     c    : 1 when a > b
//     d    : 1 when a == b
//
// comperator_sort_ctrl
//   Block sorter that time-shares one comperator_main. A block of DEPTH bytes is
//   loaded over a valid/ready input stream, bubble-sorted in place with exactly
//   one compare per cycle, then drained over a valid/ready output stream.
//   Parameters:
//     DEPTH   : bytes per block (2..16)
//     DESCEND : 0 ascending output order, 1 descending output order
//   Ports:
//     clk, rst             : rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready    : input handshake (ready only while loading)
//     in_data              : input byte
//     out_valid/out_ready  : output handshake (valid only while unloading)
//     out_data             : sorted byte, 0 when not unloading
//     busy                 : high while sorting
//     swap_cnt             : swaps made for the current/last block (saturating)
// -----------------------------------------------------------------------------
module comperator_main (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       c,
    output logic       d
);
    assign c = (a > b);
    assign d = (a == b);
endmodule

module comperator_sort_ctrl #(
    parameter int DEPTH   = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic [7:0] swap_cnt
);
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] LAST_PASS = PTR_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SORT   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  pass_q, pass_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [7:0]        swap_cnt_q, swap_cnt_d;

    logic [PTR_W-1:0]  idx_nx;
    logic [PTR_W-1:0]  last_idx;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              cmp_gt, cmp_eq;
    logic              do_swap;

    // Swap counter saturates rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Neighbouring pair under test this cycle; idx never exceeds DEPTH-2,
    // so idx+1 always stays inside the array.
    assign idx_nx   = idx_q + PTR_ONE;
    assign last_idx = LAST_PASS - pass_q;
    assign cmp_a    = mem_q[idx_q];
    assign cmp_b    = mem_q[idx_nx];

    comperator_main u_cmp (
        .a (cmp_a),
        .b (cmp_b),
        .c (cmp_gt),
        .d (cmp_eq)
    );

    // Equal bytes never swap, keeping the sort stable in both orders.
    assign do_swap = DESCEND ? (!cmp_gt && !cmp_eq) : cmp_gt;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_d     = pass_q;
        idx_d      = idx_q;
        mem_d      = mem_q;
        swap_cnt_d = swap_cnt_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_ptr_q] = in_data;
                    // The counter keeps the previous block's result until new data arrives.
                    if (wr_ptr_q == '0) begin
                        swap_cnt_d = '0;
                    end
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        pass_d   = '0;
                        idx_d    = '0;
                        state_d  = ST_SORT;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end

            ST_SORT: begin
                if (do_swap) begin
                    mem_d[idx_q]  = cmp_b;
                    mem_d[idx_nx] = cmp_a;
                    swap_cnt_d    = sat_inc(swap_cnt_q);
                end
                // Full bubble sort with no early exit: latency is fixed.
                if (idx_q == last_idx) begin
                    idx_d = '0;
                    if (pass_q == LAST_PASS) begin
                        state_d = ST_UNLOAD;
                    end else begin
                        pass_d = pass_q + PTR_ONE;
                    end
                end else begin
                    idx_d = idx_nx;
                end
            end

            ST_UNLOAD: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        rd_ptr_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_q     <= '0;
            idx_q      <= '0;
            swap_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_q     <= pass_d;
            idx_q      <= idx_d;
            swap_cnt_q <= swap_cnt_d;
            mem_q      <= mem_d;
        end
    end

    // All outputs decode from registered state only.
    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_SORT);
    assign out_valid = (state_q == ST_UNLOAD);
    assign out_data  = (state_q == ST_UNLOAD) ? mem_q[rd_ptr_q] : 8'h00;
    assign swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_comperator_sort_ctrl.sv
module tb_comperator_sort_ctrl;
    localparam int DEPTH = 4;
    localparam int SORT_CYC = DEPTH * (DEPTH - 1) / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
    logic       busy      [2];
    logic [7:0] swap_cnt  [2];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0] rblk [DEPTH];

    always #5 clk = ~clk;

    comperator_sort_ctrl #(.DEPTH(DEPTH), .DESCEND(1'b0)) u_asc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .busy      (busy[0]),
        .swap_cnt  (swap_cnt[0])
    );

    comperator_sort_ctrl #(.DEPTH(DEPTH), .DESCEND(1'b1)) u_desc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .busy      (busy[1]),
        .swap_cnt  (swap_cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sorted order from the queue sort methods, swap count as the
    // number of out-of-order pairs for the chosen direction.
    task automatic model(input bit desc, input logic [7:0] blk [DEPTH],
                         output logic [7:0] exp [DEPTH], output int inv);
        logic [7:0] q [$];
        inv = 0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = i + 1; j < DEPTH; j++) begin
                if (desc ? (blk[i] < blk[j]) : (blk[i] > blk[j])) inv++;
            end
        end
        if (inv > 255) inv = 255;
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(blk[i]);
        if (desc) q.rsort();
        else q.sort();
        for (int i = 0; i < DEPTH; i++) exp[i] = q[i];
    endtask

    // rst_at > 0 asserts reset during that SORT cycle (1-based) and abandons the block.
    task automatic run_block(input int sel, input logic [7:0] blk [DEPTH],
                             input bit stall, input int rst_at);
        logic [7:0] exp [DEPTH];
        int inv;
        int guard;
        model(sel == 1, blk, exp, inv);

        guard = 0;
        while (in_ready[sel] !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("in_ready_idle", 32'(in_ready[sel]), 32'd1);

        for (int k = 0; k < DEPTH; k++) begin
            in_valid[sel] = 1'b1;
            in_data[sel]  = blk[k];
            chk("in_ready_load", 32'(in_ready[sel]), 32'd1);
            chk("busy_load", 32'(busy[sel]), 32'd0);
            tick();
            if (k == 0) chk("swap_clear", 32'(swap_cnt[sel]), 32'd0);
        end

        // Junk on the input and a ready consumer must both be ignored while sorting.
        in_data[sel]   = 8'hA5;
        out_ready[sel] = 1'b1;
        for (int c = 0; c < SORT_CYC; c++) begin
            chk("busy_sort", 32'(busy[sel]), 32'd1);
            chk("in_ready_sort", 32'(in_ready[sel]), 32'd0);
            chk("out_valid_sort", 32'(out_valid[sel]), 32'd0);
            chk("out_data_sort", 32'(out_data[sel]), 32'd0);
            if (rst_at > 0 && c == rst_at - 1) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy[sel]), 32'd0);
                chk("rst_out_valid", 32'(out_valid[sel]), 32'd0);
                chk("rst_swap_cnt", 32'(swap_cnt[sel]), 32'd0);
                in_valid[sel]  = 1'b0;
                out_ready[sel] = 1'b0;
                tick();
                rst = 1'b0;
                return;
            end
            tick();
        end

        chk("busy_end", 32'(busy[sel]), 32'd0);
        chk("swap_cnt_sorted", 32'(swap_cnt[sel]), 32'(inv));

        for (int k = 0; k < DEPTH; k++) begin
            chk("out_valid", 32'(out_valid[sel]), 32'd1);
            chk("out_data", 32'(out_data[sel]), 32'(exp[k]));
            chk("in_ready_unload", 32'(in_ready[sel]), 32'd0);
            if (stall && k == 1) begin
                out_ready[sel] = 1'b0;
                repeat (3) begin
                    tick();
                    chk("stall_valid", 32'(out_valid[sel]), 32'd1);
                    chk("stall_data", 32'(out_data[sel]), 32'(exp[1]));
                    chk("stall_in_ready", 32'(in_ready[sel]), 32'd0);
                end
                out_ready[sel] = 1'b1;
            end
            tick();
        end

        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b0;
        chk("done_out_valid", 32'(out_valid[sel]), 32'd0);
        chk("done_out_data", 32'(out_data[sel]), 32'd0);
        chk("done_in_ready", 32'(in_ready[sel]), 32'd1);
        chk("swap_cnt_hold", 32'(swap_cnt[sel]), 32'(inv));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = 8'h00;
            out_ready[i] = 1'b0;
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", 32'(busy[i]), 32'd0);
            chk("reset_out_valid", 32'(out_valid[i]), 32'd0);
            chk("reset_out_data", 32'(out_data[i]), 32'd0);
            chk("reset_swap_cnt", 32'(swap_cnt[i]), 32'd0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_in_ready_asc", 32'(in_ready[0]), 32'd1);
        chk("post_reset_in_ready_desc", 32'(in_ready[1]), 32'd1);

        run_block(0, '{8'd3, 8'd1, 8'd2, 8'd0}, 1'b0, 0);
        run_block(0, '{8'd10, 8'd20, 8'd30, 8'd40}, 1'b0, 0);
        run_block(0, '{8'h05, 8'h05, 8'hFF, 8'h00}, 1'b0, 0);
        run_block(1, '{8'h01, 8'h80, 8'h7F, 8'hFE}, 1'b0, 0);
        run_block(0, '{8'd3, 8'd1, 8'd2, 8'd0}, 1'b1, 0);
        run_block(0, '{8'd3, 8'd1, 8'd2, 8'd0}, 1'b0, 3);
        run_block(0, '{8'd3, 8'd1, 8'd2, 8'd0}, 1'b0, 0);

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                rblk[i] = (r % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            end
            run_block(int'($urandom_range(0, 1)), rblk, 1'($urandom_range(0, 1)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
